serial_alu_ctrl: RTL
====================

SERIAL_ALU_CTRL -- requirements
Module: serial_alu_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits (legal range 2..32).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port start  input  1  request a new operation; sampled only in IDLE.
REQ-005 SHALL have port op  input  3  operation code, latched at accepted start.
REQ-006 SHALL have ports opa and opb  input  WIDTH  operands, latched at accepted start.
REQ-007 SHALL have port busy  output  1  high while an operation is in progress.
REQ-008 SHALL have port done  output  1  single-cycle pulse when res, cout and ovf become valid.
REQ-009 SHALL have port res  output  WIDTH  result; holds its value until the next accepted start.
REQ-010 SHALL have ports cout and ovf  output  1  final carry and signed overflow; both hold like res.
REQ-011 SHALL have ports alu_a, alu_b, alu_cin  output  1  bit-serial drive into the one-bit ALU.
REQ-012 SHALL have port alu_op  output  3  ALU operation select, equal to the latched op.
REQ-013 SHALL have ports alu_result and alu_cout  input  1  combinational returns from the one-bit ALU.

Function
REQ-014 SHALL implement the FSM states IDLE, RUN, DONE; leaving DONE, the FSM SHALL always go to IDLE.
REQ-015 In IDLE with start=1, the block SHALL latch opa/opb into right-shift registers and latch op, clear the bit counter, and enter RUN at that edge.
REQ-016 At accept, the carry register SHALL be loaded with 1 for OP_SUB and 0 for every other op.
REQ-017 In RUN, the block SHALL drive alu_a = opa_shift[0], alu_b = opb_shift[0], alu_cin = carry for ADD/SUB, and alu_cin = 0 otherwise.
REQ-018 At each RUN edge, the block SHALL shift alu_result into res_shift MSB (shifting right), set carry to alu_cout, shift both operand registers right, and increment the counter.
REQ-019 At the RUN edge that processes bit WIDTH-1, the block SHALL record the carry-in of that bit as cin_msb and enter DONE.
REQ-020 Latency: with start accepted at edge 0, the block SHALL spend edges 1..WIDTH in RUN and hold done high for exactly the cycle after edge WIDTH.
REQ-021 busy SHALL be high in RUN and DONE and low in IDLE.
REQ-022 In DONE, res SHALL equal res_shift, and the block SHALL hold it until the next accepted start.
REQ-023 For ADD/SUB, the block SHALL set cout to the final carry and ovf to cin_msb XOR the final carry; for all other ops, both SHALL be 0.
REQ-024 For SUB, cout=1 SHALL mean no borrow (opa >= opb unsigned).
REQ-025 The block SHALL ignore start while busy=1, including in the DONE cycle, with no effect on any state.
REQ-026 The block SHALL pass op codes outside the package set through unchanged and treat them as non-arithmetic (cin 0, cout/ovf 0).

Reset
REQ-027 On rst_n=0, the block SHALL immediately, without a clock, force state=IDLE, busy=0, done=0, res=0, cout=0, ovf=0, alu_a=alu_b=alu_cin=0, alu_op=0, counter=0, carry=0.
REQ-028 On reset asserted mid-RUN, the block SHALL abort the operation, produce no done pulse, and accept a start on the first edge after rst_n rises.

Structure
REQ-029 The codebase's shared ALU package SHALL hold OP_MOV=000, OP_NOT=001, OP_ADD=010, OP_OR=011, OP_AND=100, OP_SUB=101, and the FSM state encoding.
REQ-030 The bit counter SHALL be $clog2(WIDTH)+1 bits wide.
REQ-031 Sub-module shift_reg_w (parameterised WIDTH, load/shift-right/serial-in) SHALL be instantiated three times for opa, opb and res.
REQ-032 The block SHALL contain no arithmetic on data bits; all data computation SHALL go through the external one-bit ALU.

Verification (WIDTH=8, bench instantiates the one-bit ALU in loop)
REQ-033 ADD 0x7F+0x01 SHALL produce res=0x80, cout=0, ovf=1, with done exactly 9 cycles after the start edge.
REQ-034 SUB 0x05-0x07 SHALL produce res=0xFE, cout=0, ovf=0; SUB 0x80-0x01 SHALL produce res=0x7F, cout=1, ovf=1.
REQ-035 AND 0xF0,0x3C SHALL produce res=0x30; OR SHALL produce 0xFC; NOT 0xA5 SHALL produce 0x5A; all with cout=ovf=0 and alu_cin held 0.
REQ-036 ADD 0xFF+0x01 with start re-pulsed at cycles 3 and 9 SHALL produce one done only, with res=0x00, cout=1, ovf=0.
REQ-037 With rst_n pulsed low at cycle 4 of an ADD, outputs SHALL go to 0 asynchronously with no done; a new MOV 0x3C SHALL then produce res=0x3C.

Source files
------------

// File: rtl/serial_alu_ctrl_pkg.sv
// Shared definitions for the bit-serial ALU controller: op codes, FSM
// state encoding and a helper that classifies the carry-using ops.
package serial_alu_ctrl_pkg;

  typedef enum logic [2:0] {
    OP_MOV = 3'b000,
    OP_NOT = 3'b001,
    OP_ADD = 3'b010,
    OP_OR  = 3'b011,
    OP_AND = 3'b100,
    OP_SUB = 3'b101
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // Codes outside the set above fall through as non-arithmetic.
  function automatic logic is_arith(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/serial_alu_ctrl_shift_reg_w.sv
// Parallel-load, right-shifting register with a serial input at the MSB.
module shift_reg_w #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  input  logic             sin,
  output logic [WIDTH-1:0] q
);

  // Load wins over shift so an accept always starts from fresh data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load) begin
      q <= din;
    end else if (shift) begin
      q <= {sin, q[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/serial_alu_ctrl.sv
// Bit-serial ALU sequencer: feeds operands LSB-first into an external one-bit
// ALU and collects the result, final carry and signed overflow.
module serial_alu_ctrl
  import serial_alu_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] res,
  output logic             cout,
  output logic             ovf,
  output logic             alu_a,
  output logic             alu_b,
  output logic             alu_cin,
  output logic [2:0]       alu_op,
  input  logic             alu_result,
  input  logic             alu_cout
);

  localparam int CW = $clog2(WIDTH) + 1;

  state_e           state, state_next;
  logic [2:0]       op_reg;
  logic             carry, cin_msb;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] opa_q, opb_q, res_shift, res_q;
  logic             cout_q, ovf_q;
  logic             accept, run, last, arith, final_cout, final_ovf;
  logic             unused_bits;

  assign accept      = (state == ST_IDLE) && start;
  assign run         = (state == ST_RUN);
  assign last        = run && (cnt == CW'(WIDTH - 1));
  assign arith       = is_arith(op_reg);
  assign unused_bits = ^{opa_q[WIDTH-1:1], opb_q[WIDTH-1:1]};

  shift_reg_w #(.WIDTH(WIDTH)) u_opa (
    .clk(clk), .rst_n(rst_n), .load(accept), .shift(run),
    .din(opa), .sin(1'b0), .q(opa_q)
  );

  shift_reg_w #(.WIDTH(WIDTH)) u_opb (
    .clk(clk), .rst_n(rst_n), .load(accept), .shift(run),
    .din(opb), .sin(1'b0), .q(opb_q)
  );

  shift_reg_w #(.WIDTH(WIDTH)) u_res (
    .clk(clk), .rst_n(rst_n), .load(accept), .shift(run),
    .din('0), .sin(alu_result), .q(res_shift)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (start) state_next = ST_RUN;
      ST_RUN:  if (last)  state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Subtraction relies on the ALU inverting b, so the carry starts at 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_reg  <= '0;
      carry   <= 1'b0;
      cin_msb <= 1'b0;
      cnt     <= '0;
      res_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      if (accept) begin
        op_reg <= op;
        carry  <= (op == OP_SUB);
        cnt    <= '0;
      end else if (run) begin
        carry <= alu_cout;
        cnt   <= cnt + CW'(1);
        if (last) cin_msb <= carry;
      end
      if (state == ST_DONE) begin
        res_q  <= res_shift;
        cout_q <= final_cout;
        ovf_q  <= final_ovf;
      end
    end
  end

  assign final_cout = arith & carry;
  assign final_ovf  = arith & (cin_msb ^ carry);

  assign busy    = (state != ST_IDLE);
  assign done    = (state == ST_DONE);
  assign res     = done ? res_shift  : res_q;
  assign cout    = done ? final_cout : cout_q;
  assign ovf     = done ? final_ovf  : ovf_q;
  assign alu_a   = run & opa_q[0];
  assign alu_b   = run & opb_q[0];
  assign alu_cin = run & arith & carry;
  assign alu_op  = op_reg;

endmodule
